// File: rtl/rs_iss_sched.sv
// rs_iss_sched: issue/dispatch scheduler for a reservation-station entry array.
// Each cycle it picks the lowest-index free entry to load with the dispatched
// instruction and, using a round-robin pointer, one ready occupied entry to
// issue to the functional unit. Both grants are blocked during branch recovery
// and while reset is asserted.
module rs_iss_sched #(
  parameter int NUM_ENT = 8,
  parameter int IDX_W   = $clog2(NUM_ENT),
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_ENT-1:0] ent_avail_i,
  input  logic [NUM_ENT-1:0] ent_rdy_i,
  input  logic               dispatch_vld_i,
  input  logic               fu_rdy_i,
  input  logic               br_recovery_i,
  output logic [NUM_ENT-1:0] ent_load_o,
  output logic               dispatch_ack_o,
  output logic [NUM_ENT-1:0] ent_iss_en_o,
  output logic               iss_vld_o,
  output logic [IDX_W-1:0]   iss_idx_o,
  output logic               rs_full_o,
  output logic [IDX_W:0]     free_cnt_o,
  output logic [CNT_W-1:0]   iss_cnt_o
);

  // Issue search start position and issued-instruction statistics.
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [CNT_W-1:0]   iss_cnt_r;

  // Grant qualifiers: recovery and reset block both paths.
  logic               alloc_gate;
  logic               iss_gate;

  // Allocation search result.
  logic               alloc_hit;
  logic [NUM_ENT-1:0] alloc_sel;

  // Issue search result.
  logic [NUM_ENT-1:0] iss_cand;
  logic               iss_hit;
  logic [IDX_W-1:0]   iss_sel;
  logic [IDX_W-1:0]   iss_probe;

  assign alloc_gate = dispatch_vld_i & ~br_recovery_i & ~rst;
  assign iss_gate   = fu_rdy_i & ~br_recovery_i & ~rst;

  // Only occupied entries can issue, so loads and issues never collide.
  assign iss_cand   = ent_rdy_i & ~ent_avail_i;

  // Allocation: pick the lowest-index free entry (fixed priority).
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    alloc_hit = 1'b0;
    alloc_sel = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      if (!alloc_hit && ent_avail_i[i]) begin
        alloc_hit    = 1'b1;
        alloc_sel[i] = 1'b1;
      end
    end
  end

  assign ent_load_o     = alloc_gate ? alloc_sel : '0;
  assign dispatch_ack_o = alloc_gate & alloc_hit;

  // Issue: circular search starting at rr_ptr_r; index arithmetic wraps
  // naturally because NUM_ENT is a power of two.
  always_comb begin
    iss_hit   = 1'b0;
    iss_sel   = '0;
    iss_probe = '0;
    for (int k = 0; k < NUM_ENT; k++) begin
      iss_probe = rr_ptr_r + IDX_W'(k);
      if (!iss_hit && iss_cand[iss_probe]) begin
        iss_hit = 1'b1;
        iss_sel = iss_probe;
      end
    end
  end

  assign iss_vld_o    = iss_gate & iss_hit;
  assign iss_idx_o    = iss_vld_o ? iss_sel : '0;
  assign ent_iss_en_o = iss_vld_o ? (NUM_ENT'(1) << iss_sel) : '0;

  // Occupancy status: pure functions of the free flags, valid during recovery.
  always_comb begin
    free_cnt_o = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      free_cnt_o = free_cnt_o + (IDX_W+1)'(ent_avail_i[i]);
    end
  end

  assign rs_full_o = ~|ent_avail_i;
  assign iss_cnt_o = iss_cnt_r;

  // Advance the round-robin pointer past the issued entry and count issues.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      rr_ptr_r  <= '0;
      iss_cnt_r <= '0;
    end else if (iss_vld_o) begin
      rr_ptr_r  <= iss_idx_o + IDX_W'(1);
      iss_cnt_r <= iss_cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rs_iss_sched.sv
// tb_rs_iss_sched: directed plus randomized checks of rs_iss_sched against a
// behavioural scheduler model (lowest free slot, circular ready search).
module tb_rs_iss_sched;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] ent_avail_i = '0;
  logic [N-1:0] ent_rdy_i = '0;
  logic         dispatch_vld_i = 1'b0;
  logic         fu_rdy_i = 1'b0;
  logic         br_recovery_i = 1'b0;
  logic [N-1:0] ent_load_o;
  logic         dispatch_ack_o;
  logic [N-1:0] ent_iss_en_o;
  logic         iss_vld_o;
  logic [2:0]   iss_idx_o;
  logic         rs_full_o;
  logic [3:0]   free_cnt_o;
  logic [15:0]  iss_cnt_o;

  rs_iss_sched #(.NUM_ENT(N), .IDX_W(3), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .ent_avail_i    (ent_avail_i),
    .ent_rdy_i      (ent_rdy_i),
    .dispatch_vld_i (dispatch_vld_i),
    .fu_rdy_i       (fu_rdy_i),
    .br_recovery_i  (br_recovery_i),
    .ent_load_o     (ent_load_o),
    .dispatch_ack_o (dispatch_ack_o),
    .ent_iss_en_o   (ent_iss_en_o),
    .iss_vld_o      (iss_vld_o),
    .iss_idx_o      (iss_idx_o),
    .rs_full_o      (rs_full_o),
    .free_cnt_o     (free_cnt_o),
    .iss_cnt_o      (iss_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  int ref_ptr = 0;
  int ref_cnt = 0;

  // Last sampled outputs, for literal checks in directed tests.
  logic [N-1:0] obs_load;
  logic [N-1:0] obs_iss;
  logic [2:0]   obs_idx;
  logic [15:0]  obs_cnt;
  logic         obs_ack;
  logic         obs_full;
  logic [3:0]   obs_free;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // One cycle: drive at negedge, check outputs against the model, then
  // advance the model at the following posedge.
  task automatic step(input logic [N-1:0] av, input logic [N-1:0] rd,
                      input logic dv, input logic fr, input logic br, input logic rs);
    logic [N-1:0] exp_load;
    logic [N-1:0] exp_iss;
    logic [N-1:0] cand;
    logic         exp_vld;
    int           exp_idx;
    bit           got;
    @(negedge clk);
    ent_avail_i    = av;
    ent_rdy_i      = rd;
    dispatch_vld_i = dv;
    fu_rdy_i       = fr;
    br_recovery_i  = br;
    rst            = rs;
    #1;
    exp_load = '0;
    got = 1'b0;
    if (dv && !br && !rs)
      for (int i = 0; i < N; i++)
        if (!got && av[i]) begin exp_load[i] = 1'b1; got = 1'b1; end
    cand    = rd & ~av;
    exp_vld = 1'b0;
    exp_idx = 0;
    if (fr && !br && !rs)
      for (int k = 0; k < N; k++) begin
        int j;
        j = (ref_ptr + k) % N;
        if (!exp_vld && cand[j]) begin exp_vld = 1'b1; exp_idx = j; end
      end
    exp_iss = '0;
    if (exp_vld) exp_iss[exp_idx] = 1'b1;

    obs_load = ent_load_o;   obs_iss  = ent_iss_en_o; obs_idx  = iss_idx_o;
    obs_cnt  = iss_cnt_o;    obs_ack  = dispatch_ack_o;
    obs_full = rs_full_o;    obs_free = free_cnt_o;

    check("load",     32'(ent_load_o),     32'(exp_load));
    check("ack",      32'(dispatch_ack_o), 32'(exp_load != 0));
    check("iss_en",   32'(ent_iss_en_o),   32'(exp_iss));
    check("iss_vld",  32'(iss_vld_o),      32'(exp_vld));
    check("iss_idx",  32'(iss_idx_o),      32'(exp_idx));
    check("full",     32'(rs_full_o),      32'(av == 0));
    check("free_cnt", 32'(free_cnt_o),     32'($countones(av)));
    check("iss_cnt",  32'(iss_cnt_o),      32'(ref_cnt));

    @(posedge clk);
    if (rs) begin
      ref_ptr = 0;
      ref_cnt = 0;
    end else if (exp_vld) begin
      ref_ptr = (exp_idx + 1) % N;
      ref_cnt = (ref_cnt + 1) % 65536;
    end
  endtask

  initial begin
    // Reset with everything requesting: no grants.
    step(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
    check("rst_load", 32'(obs_load), 32'h0);
    step(8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
    check("rst_iss",  32'(obs_iss),  32'h0);

    // Allocation priority and full detection.
    step(8'b0010_1100, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("alloc_lsb",  32'(obs_load), 32'h04);
    check("alloc_free", 32'(obs_free), 32'd3);
    step(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("alloc_full_ack", 32'(obs_ack),  32'd0);
    check("alloc_full",     32'(obs_full), 32'd1);

    // Round robin across all entries: 0..7,0,1, first issue at idx 0.
    for (int c = 0; c < 10; c++) begin
      step(8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
      check("rr_idx", 32'(obs_idx), 32'(c % N));
    end

    // Move pointer to 6 via a single candidate at idx 5; count reads 10.
    step(~8'h20, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0);
    check("rr_cnt10", 32'(obs_cnt), 32'd10);
    check("ptr_to_6", 32'(obs_idx), 32'd5);

    // Skip/wrap from pointer 6 over candidates {0,2}.
    step(8'hFA, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0);
    check("wrap_idx0", 32'(obs_idx), 32'd0);
    step(8'hFA, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0);
    check("wrap_idx2", 32'(obs_idx), 32'd2);

    // FU stall and branch recovery: no grants, pointer holds at 3.
    step(8'hFA, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'hFA, 8'h05, 1'b1, 1'b1, 1'b1, 1'b0);
    check("rec_load", 32'(obs_load), 32'h0);
    check("rec_iss",  32'(obs_iss),  32'h0);
    check("rec_free", 32'(obs_free), 32'd6);
    step(8'hF0, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0);
    check("hold_ptr", 32'(obs_idx), 32'd3);

    // Simultaneous load and issue right after a mid-run reset.
    step(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
    step(8'h0F, 8'hF0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("sim_load", 32'(obs_load), 32'h01);
    check("sim_iss",  32'(obs_iss),  32'h10);

    // Randomized traffic with occasional recovery and reset.
    for (int c = 0; c < 3000; c++) begin
      step(N'($urandom), N'($urandom), 1'($urandom),
           ($urandom_range(3) != 0), ($urandom_range(7) == 0),
           ($urandom_range(63) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
